// File: rtl/irq_pending_capture.sv
// Request capture for the 8-to-3 priority encoder: edge/level pending register plus frozen masked snapshot.
// Latency: request to irq_req is 2 cycles; irq_ack retires the snapshot and allows a new one one IDLE cycle later.
module irq_pending_capture #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_in,
  input  logic [N-1:0]   mode,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   pend_vec,
  output logic           irq_req,
  input  logic           irq_ack,
  input  logic [IDW-1:0] ack_id,
  output logic [N-1:0]   pending
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t       state, state_next;
  logic [N-1:0] req_d;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] pending_next;
  logic [N-1:0] pend_vec_next;
  logic [N-1:0] unmasked;

  // Edge detection runs regardless of mask and state, so edges seen during REQ accumulate.
  assign set_vec      = (mode & req_in & ~req_d) | (~mode & req_in);
  assign clr_vec      = (state == REQ && irq_ack) ? ({{(N-1){1'b0}}, 1'b1} << ack_id) : '0;
  assign pending_next = set_vec | (pending & ~clr_vec);
  assign unmasked     = pending & ~mask;
  assign irq_req      = (state == REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d    <= '0;
      pending  <= '0;
      state    <= IDLE;
      pend_vec <= '0;
    end else begin
      req_d    <= req_in;
      pending  <= pending_next;
      state    <= state_next;
      pend_vec <= pend_vec_next;
    end
  end

  always_comb begin
    state_next    = state;
    pend_vec_next = pend_vec;
    case (state)
      IDLE: begin
        pend_vec_next = '0;
        if (|unmasked) begin
          pend_vec_next = unmasked;
          state_next    = REQ;
        end
      end
      REQ: begin
        // ack_id is deliberately not checked against the snapshot.
        if (irq_ack) begin
          pend_vec_next = '0;
          state_next    = IDLE;
        end
      end
      default: begin
        pend_vec_next = '0;
        state_next    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_pending_capture.sv
// Directed bench for irq_pending_capture with hand-computed expectations.
module tb_irq_pending_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mode;
  logic [7:0] mask;
  logic [7:0] pend_vec;
  logic       irq_req;
  logic       irq_ack;
  logic [2:0] ack_id;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  irq_pending_capture #(.N(8), .IDW(3)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mode(mode), .mask(mask),
    .pend_vec(pend_vec), .irq_req(irq_req), .irq_ack(irq_ack),
    .ack_id(ack_id), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_in = 8'h00; mode = 8'hFF; mask = 8'h00; irq_ack = 1'b0; ack_id = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", pending, 8'h00);
    chk("rst_pend_vec", pend_vec, 8'h00);
    chk("rst_irq_req", {7'b0, irq_req}, 8'h00);
    rst = 1'b0;

    // Basic edge request, ack of encoder output 5, follow-up REQ for bit 2
    req_in = 8'h24; tick();
    chk("t1_pending", pending, 8'h24);
    chk("t1_irq_early", {7'b0, irq_req}, 8'h00);
    tick();
    chk("t1_irq_req", {7'b0, irq_req}, 8'h01);
    chk("t1_pend_vec", pend_vec, 8'h24);
    irq_ack = 1'b1; ack_id = 3'd5; tick();
    chk("t1_ack_pending", pending, 8'h04);
    chk("t1_ack_irq", {7'b0, irq_req}, 8'h00);
    chk("t1_ack_vec", pend_vec, 8'h00);
    irq_ack = 1'b0; tick();
    chk("t1_rereq_irq", {7'b0, irq_req}, 8'h01);
    chk("t1_rereq_vec", pend_vec, 8'h04);
    irq_ack = 1'b1; ack_id = 3'd2; tick();
    chk("t1_clear_all", pending, 8'h00);
    irq_ack = 1'b0; req_in = 8'h00; tick();

    // Masked line still pends; unmasking raises irq one cycle later
    mask = 8'h80; req_in = 8'h80; tick();
    chk("t2_pending", pending, 8'h80);
    tick();
    chk("t2_masked_irq", {7'b0, irq_req}, 8'h00);
    chk("t2_masked_vec", pend_vec, 8'h00);
    mask = 8'h00; tick();
    chk("t2_unmask_irq", {7'b0, irq_req}, 8'h01);
    chk("t2_unmask_vec", pend_vec, 8'h80);
    irq_ack = 1'b1; ack_id = 3'd7; tick();
    irq_ack = 1'b0; req_in = 8'h00; tick();

    // Snapshot frozen during REQ
    req_in = 8'h02; tick(); tick();
    chk("t3_vec", pend_vec, 8'h02);
    req_in = 8'h42; mask = 8'hFF; tick();
    chk("t3_frozen_vec", pend_vec, 8'h02);
    chk("t3_accum_pending", pending, 8'h42);
    chk("t3_still_req", {7'b0, irq_req}, 8'h01);
    irq_ack = 1'b1; ack_id = 3'd1; tick();
    chk("t3_ack_pending", pending, 8'h40);
    irq_ack = 1'b0; tick();
    chk("t3_masked_idle", {7'b0, irq_req}, 8'h00);
    mask = 8'h00; tick();
    chk("t3_next_vec", pend_vec, 8'h40);
    irq_ack = 1'b1; ack_id = 3'd6; tick();
    chk("t3_cleared", pending, 8'h00);
    irq_ack = 1'b0; req_in = 8'h00; tick();

    // Level-mode line 3 held high is re-requested after ack
    mode = 8'hF7; req_in = 8'h08; tick();
    chk("t4_pending", pending, 8'h08);
    tick();
    chk("t4_vec", pend_vec, 8'h08);
    irq_ack = 1'b1; ack_id = 3'd3; tick();
    chk("t4_level_reset", pending, 8'h08);
    chk("t4_idle_gap", {7'b0, irq_req}, 8'h00);
    irq_ack = 1'b0; tick();
    chk("t4_rereq", {7'b0, irq_req}, 8'h01);
    req_in = 8'h00; irq_ack = 1'b1; ack_id = 3'd3; tick();
    chk("t4_dropped", pending, 8'h00);
    irq_ack = 1'b0; tick();
    chk("t4_no_req", {7'b0, irq_req}, 8'h00);
    mode = 8'hFF;

    // Set wins over clear in the same cycle
    req_in = 8'h01; tick(); tick();
    chk("t5_req", {7'b0, irq_req}, 8'h01);
    req_in = 8'h00; tick();
    req_in = 8'h01; irq_ack = 1'b1; ack_id = 3'd0; tick();
    chk("t5_set_wins", pending, 8'h01);
    chk("t5_irq_drop", {7'b0, irq_req}, 8'h00);
    irq_ack = 1'b0; tick();
    chk("t5_rereq_vec", pend_vec, 8'h01);

    // Asynchronous reset mid-REQ, then ack ignored in IDLE
    req_in = 8'hFF; tick();
    chk("t6_pending_ff", pending, 8'hFF);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_pending", pending, 8'h00);
    chk("t6_async_vec", pend_vec, 8'h00);
    chk("t6_async_irq", {7'b0, irq_req}, 8'h00);
    rst = 1'b0; tick();
    chk("t6_post_rst_edge", pending, 8'hFF);
    irq_ack = 1'b1; ack_id = 3'd4; tick();
    chk("t6_idle_ack_ignored", pending, 8'hFF);
    chk("t6_req_vec", pend_vec, 8'hFF);
    irq_ack = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_capture.md
# irq_pending_capture

Upstream request-capture stage for the 8-to-3 priority encoder. Samples raw request lines with per-line rising-edge or level detection, and keeps a pending register. It presents a masked, stable snapshot of pending requests on `pend_vec`, which drives the encoder's `in` input directly. A req/ack handshake with the servicing agent clears the serviced pending bit, and the snapshot is held frozen while a request is outstanding.

## Interface
- `N`, 8, number of request lines. The only supported value is 8, matching the encoder width.
- `IDW`, 3, width of `ack_id`. Fixed at $clog2(N).

- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_in`  in  N  raw request lines, synchronous to `clk`.
- `mode`  in  N  per line: 1 = rising-edge detect, 0 = level detect.
- `mask`  in  N  per line: 1 = excluded from the snapshot. A masked line still sets its pending bit.
- `pend_vec`  out  N  masked pending snapshot. Connects to the encoder `in`.
- `irq_req`  out  1  a snapshot is outstanding and awaiting acknowledge.
- `irq_ack`  in  1  acknowledge strobe, one cycle.
- `ack_id`  in  IDW  index being acknowledged. Normally the encoder `out`.
- `pending`  out  N  raw pending register, exposed for status.

## Operation
- Registers:
  - `req_d` [N]: previous `req_in`.
  - `pending` [N].
  - `state` ∈ {IDLE, REQ}.
  - `pend_vec` [N].
- Set term per bit i:
  - If `mode[i]`=1: `set_i` = `req_in[i]` & ~`req_d[i]`.
  - Otherwise: `set_i` = `req_in[i]`.
- Clear term: `clr_i` = (`state`==REQ) & `irq_ack` & (`ack_id`==i).
- Pending update: next `pending[i]` = `set_i` | (`pending[i]` & ~`clr_i`). Set wins over a clear in the same cycle.
- IDLE state:
  - `irq_req`=0 and `pend_vec`=0.
  - If (`pending` & ~`mask`) != 0, load `pend_vec` <= `pending` & ~`mask` (registered values) and go to REQ.
  - `irq_ack` in IDLE is ignored and clears nothing.
- REQ state:
  - `irq_req`=1. `pend_vec` is held constant. Changes to `mask`, `req_in` or `pending` do not alter it.
  - On `irq_ack`=1: clear `pending[ack_id]`, clear `pend_vec` to 0, go to IDLE.
  - `ack_id` is not checked against `pend_vec`. Acknowledging a non-snapshot bit still clears that pending bit and ends the REQ.
- A level-mode line still high at ack time re-sets its pending bit in the same cycle. It is therefore re-requested.
- Edge detection on `mode`=1 lines is independent of `mask` and of `state`. Edges arriving during REQ accumulate in `pending`.

## Timing
- Reset values: `pending`=0, `req_d`=0, `state`=IDLE, `pend_vec`=0, `irq_req`=0.
- Because `req_d` resets to 0, an edge-mode line already high at the first post-reset edge counts as a rising edge.
- Reset asserted mid-REQ aborts the REQ immediately (asynchronously). No ack is required.
- Sequence from request to acknowledge:
  - `req_in` edge/level sampled at edge k → `pending` bit set after k.
  - At edge k+1 the state enters REQ; `irq_req`=1 and `pend_vec` are valid after k+1. Request-to-`irq_req` latency is 2 cycles.
  - Ack sampled at edge m → after m: `irq_req`=0, `pend_vec`=0, bit cleared.
  - The earliest next REQ begins after edge m+1. There is at least one IDLE cycle between consecutive requests.
- The encoder is combinational. Its `out`/`valid` are stable for the entire REQ period, so `ack_id` may be taken directly from its `out`.
- All lines masked with pending bits set: the block stays in IDLE, `pend_vec`=0, and the encoder `valid`=0. Unmasking triggers REQ one cycle later.

## Test plan
- Reset, `mode`=FF, `req_in` rises 00→24 at edge 1 → `pending`=24 after edge 1. After edge 2: `irq_req`=1, `pend_vec`=24, encoder out=5. Ack with id 5 → `pending`=04, `irq_req`=0. One IDLE cycle, then REQ with `pend_vec`=04.
- `mask`=80, edge on line 7 → `pending`=80, `irq_req` stays 0. Set `mask`=00 → `irq_req`=1 one cycle later with `pend_vec`=80.
- In REQ with `pend_vec`=02, new edge on line 6 and `mask` changed to FF → `pend_vec` stays 02. Ack id 1 → next REQ has `pend_vec`=40 only after `mask` clears.
- Line 3 in level mode held high; ack id 3 → `pending[3]` remains 1 and REQ recurs after one IDLE cycle. Drop `req_in[3]` and ack → `pending`=00, `irq_req` stays 0.
- Edge on line 0 in the same cycle as an ack of id 0 → `pending[0]` stays 1.
- Assert `rst` mid-REQ with `pending`=FF → all outputs 0 immediately. An `irq_ack` pulse in IDLE leaves `pending` unchanged.
